branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Resolves the front-end prediction against the actual outcome in EX.
- Carries each fetched instruction's prediction (predicted-taken flag and predicted PC) through ID and EX as shadow pipeline state.
- In EX, compares that prediction with the real control-flow result. On a miss it raises flush and redirect to the PC mux.
- Issues one registered predictor-update write per resolved control instruction. This is the write side that keeps the BTB/2-bit tables trained.
- Keeps saturating branch and mispredict counters for the perf CSRs.

Parameters:
- XLEN, 32, PC/target width
- CNT_W, 32, width of each performance counter

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_stall  in  1  pipeline hold; freezes shadow ID/EX state
- i_flush_ext  in  1  external flush (interrupt/trap entry); interrupt unit owns PC this cycle
- i_pred_taken_IF  in  1  fetch-stage prediction: taken
- i_pred_pc_IF  in  XLEN  fetch-stage predicted next PC
- i_pc_EX  in  XLEN  PC of instruction in EX
- i_instr_EX  in  32  instruction in EX
- i_taken_EX  in  1  actual taken (branch compare result; 1 for JAL/JALR)
- i_alu_data  in  XLEN  actual target computed by ALU
- o_flush  out  1  kill IF/ID and ID/EX contents
- o_pc_sel_redirect  out  1  select o_redirect_pc at the PC mux
- o_redirect_pc  out  XLEN  corrected next PC
- o_upd_valid  out  1  predictor write strobe, 1-cycle pulse
- o_upd_pc  out  XLEN  PC of the resolved instruction
- o_upd_target  out  XLEN  actual target
- o_upd_taken  out  1  actual outcome
- o_br_count  out  CNT_W  resolved control instructions
- o_mispred_count  out  CNT_W  mispredict events

Behaviour:

Shadow pipeline
- Two registers, sh_ID and sh_EX, each holding {valid, pred_taken, pred_pc}.
- Reset: both valid=0, fields 0.
- Priority on each clock edge:
  1. If o_flush or i_flush_ext: both valid <= 0.
  2. Else if i_stall: hold.
  3. Else: sh_EX <= sh_ID; sh_ID <= {1, i_pred_taken_IF, i_pred_pc_IF}.

Resolution (combinational, same cycle as EX)
- is_ctrl: opcode i_instr_EX[6:0] is 1100011 (branch), 1101111 (JAL) or 1100111 (JALR).
- resolve = sh_EX.valid & !i_stall.
- A mispredict is any of the following, when resolve is true:
  - is_ctrl & (i_taken_EX != pred_taken)
  - is_ctrl & i_taken_EX & pred_taken & (pred_pc != i_alu_data)
  - !is_ctrl & pred_taken (BTB alias on a non-control instruction)
- Redirect target: o_redirect_pc = (is_ctrl & i_taken_EX) ? i_alu_data : i_pc_EX + 4, modulo 2^XLEN (wraps).
- o_flush = mispredict.
- o_pc_sel_redirect = mispredict & !i_flush_ext. The interrupt path wins PC selection, but the flush is still asserted.
- When not mispredicting, o_redirect_pc is don't-care; drive it 0.
- While i_stall: no flush, no redirect, no update. The EX instruction resolves on the first non-stalled cycle.

Update port (registered, 1-cycle latency)
- On the edge after a cycle with resolve & is_ctrl:
  - o_upd_valid = 1
  - o_upd_pc = i_pc_EX
  - o_upd_target = i_alu_data
  - o_upd_taken = i_taken_EX
- Otherwise o_upd_valid = 0 and the other upd fields hold their last values.
- The update is still issued if i_flush_ext coincides, because the EX instruction completes.
- A non-control alias does not produce an update.

Counters
- Registered; saturate at all-ones (no wrap).
- o_br_count: +1 per resolve & is_ctrl.
- o_mispred_count: +1 per mispredict.

Reset
- Asserting i_rst at any time immediately clears all registers and counters; combinational outputs fall to 0 because valid=0.
- After release, the first valid EX entry appears 2 unstalled cycles later.

Test Plan:
1. Correct prediction: BEQ at 0x100 with pred_taken=1, pred_pc=0x140; in EX, i_taken_EX=1, i_alu_data=0x140 -> o_flush=0; next cycle o_upd_valid=1, upd_pc=0x100, upd_target=0x140, taken=1; br_count=1, mispred_count=0.
2. Direction miss: BNE at 0x200 predicted not taken; actual taken, target 0x1C0 -> same cycle o_flush=1, o_pc_sel_redirect=1, o_redirect_pc=0x1C0; the following two EX cycles carry valid=0 (no update, no flush); mispred_count=1.
3. Target miss plus alias: JALR at 0x300 with pred_pc=0x400 and actual 0x480 -> redirect to 0x480. Then ADDI at 0x500 with pred_taken=1 -> flush, redirect 0x504, and no o_upd_valid.
4. Stall and wrap: mispredicted branch held in EX with i_stall=1 for 3 cycles -> no flush during the stall, flush on the release cycle. Also: non-taken branch at 0xFFFFFFFC predicted taken -> o_redirect_pc=0x00000000.
5. Simultaneous i_flush_ext with a mispredict -> o_flush=1, o_pc_sel_redirect=0, update still issued. Then assert i_rst mid-stream -> all outputs 0 within the same cycle and counters cleared.
6. Saturation: with CNT_W=4, 17 consecutive mispredicts -> o_mispred_count stays at 15.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_if
// Bundles the pipeline-facing signals of the branch resolve unit.
//   slave  : the branch resolve unit itself (consumes IF/EX info, drives
//            flush/redirect, predictor update and perf counters)
//   master : the surrounding pipeline / predictor / CSR side
// Signals:
//   i_stall, i_flush_ext        pipeline hold, external (trap) flush
//   i_pred_taken_IF, i_pred_pc_IF   fetch-stage prediction
//   i_pc_EX, i_instr_EX, i_taken_EX, i_alu_data   EX-stage actual outcome
//   o_flush, o_pc_sel_redirect, o_redirect_pc     mispredict recovery
//   o_upd_valid/pc/target/taken                   predictor training write
//   o_br_count, o_mispred_count                   saturating perf counters
// -----------------------------------------------------------------------------
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             i_stall;
  logic             i_flush_ext;
  logic             i_pred_taken_IF;
  logic [XLEN-1:0]  i_pred_pc_IF;
  logic [XLEN-1:0]  i_pc_EX;
  logic [31:0]      i_instr_EX;
  logic             i_taken_EX;
  logic [XLEN-1:0]  i_alu_data;
  logic             o_flush;
  logic             o_pc_sel_redirect;
  logic [XLEN-1:0]  o_redirect_pc;
  logic             o_upd_valid;
  logic [XLEN-1:0]  o_upd_pc;
  logic [XLEN-1:0]  o_upd_target;
  logic             o_upd_taken;
  logic [CNT_W-1:0] o_br_count;
  logic [CNT_W-1:0] o_mispred_count;

  modport master (
    output i_stall, i_flush_ext, i_pred_taken_IF, i_pred_pc_IF,
           i_pc_EX, i_instr_EX, i_taken_EX, i_alu_data,
    input  o_flush, o_pc_sel_redirect, o_redirect_pc,
           o_upd_valid, o_upd_pc, o_upd_target, o_upd_taken,
           o_br_count, o_mispred_count
  );

  modport slave (
    input  i_stall, i_flush_ext, i_pred_taken_IF, i_pred_pc_IF,
           i_pc_EX, i_instr_EX, i_taken_EX, i_alu_data,
    output o_flush, o_pc_sel_redirect, o_redirect_pc,
           o_upd_valid, o_upd_pc, o_upd_target, o_upd_taken,
           o_br_count, o_mispred_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Carries each fetched instruction's prediction through ID/EX as shadow state,
// checks it against the real control-flow outcome in EX, and on a miss raises
// flush plus a redirect PC. Every resolved control instruction produces one
// registered predictor-update pulse; branch and mispredict counts saturate.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : branch_resolve_unit_if.slave (see interface for signals)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic                  i_clk,
  input logic                  i_rst,
  branch_resolve_unit_if.slave bus
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

  logic            sh_id_valid_q, sh_id_valid_d;
  logic            sh_id_taken_q, sh_id_taken_d;
  logic [XLEN-1:0] sh_id_pc_q,    sh_id_pc_d;
  logic            sh_ex_valid_q, sh_ex_valid_d;
  logic            sh_ex_taken_q, sh_ex_taken_d;
  logic [XLEN-1:0] sh_ex_pc_q,    sh_ex_pc_d;

  logic            upd_valid_q,  upd_valid_d;
  logic [XLEN-1:0] upd_pc_q,     upd_pc_d;
  logic [XLEN-1:0] upd_target_q, upd_target_d;
  logic            upd_taken_q,  upd_taken_d;

  logic [CNT_W-1:0] br_cnt_q,  br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic            is_ctrl;
  logic            resolve;
  logic            mispred;
  logic [XLEN-1:0] actual_next_pc;

  // Classify the EX instruction and decide whether its prediction was wrong.
  always_comb begin
    case (bus.i_instr_EX[6:0])
      OP_BRANCH, OP_JAL, OP_JALR: is_ctrl = 1'b1;
      default:                    is_ctrl = 1'b0;
    endcase
    resolve = sh_ex_valid_q & ~bus.i_stall;
    // Fall-through wraps modulo 2^XLEN by plain truncation.
    if (is_ctrl && bus.i_taken_EX) begin
      actual_next_pc = bus.i_alu_data;
    end else begin
      actual_next_pc = bus.i_pc_EX + {{(XLEN-3){1'b0}}, 3'd4};
    end
    if (!resolve) begin
      mispred = 1'b0;
    end else if (is_ctrl) begin
      mispred = (bus.i_taken_EX != sh_ex_taken_q) |
                (bus.i_taken_EX & sh_ex_taken_q & (sh_ex_pc_q != bus.i_alu_data));
    end else begin
      // A taken prediction on a non-control instruction is a BTB alias.
      mispred = sh_ex_taken_q;
    end
  end

  // Shadow ID/EX next state: flush beats stall beats advance.
  always_comb begin
    sh_id_valid_d = sh_id_valid_q;
    sh_id_taken_d = sh_id_taken_q;
    sh_id_pc_d    = sh_id_pc_q;
    sh_ex_valid_d = sh_ex_valid_q;
    sh_ex_taken_d = sh_ex_taken_q;
    sh_ex_pc_d    = sh_ex_pc_q;
    if (mispred || bus.i_flush_ext) begin
      sh_id_valid_d = 1'b0;
      sh_ex_valid_d = 1'b0;
    end else if (bus.i_stall) begin
      sh_id_valid_d = sh_id_valid_q;
      sh_ex_valid_d = sh_ex_valid_q;
    end else begin
      sh_ex_valid_d = sh_id_valid_q;
      sh_ex_taken_d = sh_id_taken_q;
      sh_ex_pc_d    = sh_id_pc_q;
      sh_id_valid_d = 1'b1;
      sh_id_taken_d = bus.i_pred_taken_IF;
      sh_id_pc_d    = bus.i_pred_pc_IF;
    end
  end

  // Predictor update and counter next state. The update is issued even when
  // an external flush coincides, since the EX instruction still completes.
  always_comb begin
    upd_valid_d  = resolve & is_ctrl;
    upd_pc_d     = upd_pc_q;
    upd_target_d = upd_target_q;
    upd_taken_d  = upd_taken_q;
    if (resolve && is_ctrl) begin
      upd_pc_d     = bus.i_pc_EX;
      upd_target_d = bus.i_alu_data;
      upd_taken_d  = bus.i_taken_EX;
    end else begin
      upd_pc_d     = upd_pc_q;
    end
    br_cnt_d  = sat_inc(br_cnt_q, resolve & is_ctrl);
    mis_cnt_d = sat_inc(mis_cnt_q, mispred);
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sh_id_valid_q <= 1'b0;
      sh_id_taken_q <= 1'b0;
      sh_id_pc_q    <= {XLEN{1'b0}};
      sh_ex_valid_q <= 1'b0;
      sh_ex_taken_q <= 1'b0;
      sh_ex_pc_q    <= {XLEN{1'b0}};
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= {XLEN{1'b0}};
      upd_target_q  <= {XLEN{1'b0}};
      upd_taken_q   <= 1'b0;
      br_cnt_q      <= {CNT_W{1'b0}};
      mis_cnt_q     <= {CNT_W{1'b0}};
    end else begin
      sh_id_valid_q <= sh_id_valid_d;
      sh_id_taken_q <= sh_id_taken_d;
      sh_id_pc_q    <= sh_id_pc_d;
      sh_ex_valid_q <= sh_ex_valid_d;
      sh_ex_taken_q <= sh_ex_taken_d;
      sh_ex_pc_q    <= sh_ex_pc_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_target_q  <= upd_target_d;
      upd_taken_q   <= upd_taken_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  // Recovery outputs are combinational in EX; the interrupt path owns the PC
  // mux when it flushes, so only o_flush stays up in that case.
  assign bus.o_flush           = mispred;
  assign bus.o_pc_sel_redirect = mispred & ~bus.i_flush_ext;
  assign bus.o_redirect_pc     = mispred ? actual_next_pc : {XLEN{1'b0}};

  assign bus.o_upd_valid     = upd_valid_q;
  assign bus.o_upd_pc        = upd_pc_q;
  assign bus.o_upd_target    = upd_target_q;
  assign bus.o_upd_taken     = upd_taken_q;
  assign bus.o_br_count      = br_cnt_q;
  assign bus.o_mispred_count = mis_cnt_q;

endmodule
